// File: rtl/imem_loader.sv
// Instruction-memory loader: streams host bytes into the instruction memory
// big-endian per word, holding the CPU while the image is loaded.
module imem_loader #(
    parameter int          MEM_BYTES = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  len_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  checksum
);

    localparam int CW = $clog2(MEM_BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_last;
    logic [7:0]    r_sum;
    logic          r_err;

    logic w_in_load;
    logic w_len_ok;
    logic w_accept;
    logic w_final;

    // Handshake: a byte transfers in exactly the cycles where byte_valid and
    // byte_ready are both high; byte_ready depends only on state, never on valid.
    assign w_in_load = !rst && (r_state == S_LOAD);
    assign w_len_ok  = (len_words != 9'd0) && ({23'd0, len_words} <= 32'(MEM_BYTES / 4));
    assign w_accept  = w_in_load && byte_valid;
    assign w_final   = w_accept && (r_cnt == r_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= '0;
            r_sum   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_state <= S_LOAD;
                            r_last  <= CW'({len_words, 2'b00} - 11'd1);
                            r_cnt   <= '0;
                            r_sum   <= 8'd0;
                            r_err   <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_sum <= r_sum + byte_data;
                        // Counter wraps to 0 on the last byte so wr_addr stays in range.
                        if (w_final) begin
                            r_cnt   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign byte_ready = w_in_load;
    assign cpu_hold   = w_in_load;
    assign busy       = w_in_load;
    assign wr_en      = w_accept;
    assign wr_data    = w_accept ? byte_data : 8'd0;
    assign wr_addr    = rst ? BASE_ADDR : (BASE_ADDR + 32'(r_cnt));
    assign done       = !rst && (r_state == S_DONE);
    assign err        = r_err;
    assign checksum   = r_sum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-level memory model plus immediate
// assertions on every observed output.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  len_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  checksum;

    int n_cmp;
    int n_fail;
    int n_writes;
    int n_oob;
    logic [31:0] last_addr;
    logic [7:0]  mem [0:1023];

    imem_loader #(.MEM_BYTES(1024), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start), .len_words(len_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .err(err), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: captures every write strobe seen at the clock edge.
    always @(posedge clk) begin
        if (wr_en) begin
            if (wr_addr > 32'd1023) n_oob++;
            else mem[wr_addr[9:0]] = wr_data;
            n_writes++;
            last_addr = wr_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        int w0;
        int cyc;
        logic [7:0] b;
        n_cmp = 0; n_fail = 0; n_writes = 0; n_oob = 0; last_addr = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        rst = 1'b1; start = 1'b0; len_words = 9'd0; byte_valid = 1'b1; byte_data = 8'hAA;

        // Reset: outputs forced quiet even with byte_valid high.
        tick(); tick();
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        rst = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        tick();
        chk("idle_wr_en", 32'(wr_en), 32'd0);

        // Scenario 1: two words back-to-back; start cycle counts as cycle 1.
        w0 = n_writes;
        start = 1'b1; len_words = 9'd2; cyc = 1;
        #1 chk("s1_idle_busy", 32'(busy), 32'd0);
        tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1; byte_data = 8'(i + 1); cyc++;
            #1;
            chk("s1_wr_en", 32'(wr_en), 32'd1);
            chk("s1_wr_addr", wr_addr, 32'(i));
            chk("s1_wr_data", 32'(wr_data), 32'(i + 1));
            chk("s1_done_early", 32'(done), 32'd0);
            tick();
        end
        byte_valid = 1'b0; cyc++;
        #1;
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_done_cycle", 32'(cyc), 32'd10);
        chk("s1_ready_after", 32'(byte_ready), 32'd0);
        chk("s1_hold_done", 32'(cpu_hold), 32'd0);
        chk("s1_checksum", 32'(checksum), 32'h24);
        tick();
        chk("s1_done_off", 32'(done), 32'd0);
        chk("s1_checksum_hold", 32'(checksum), 32'h24);
        chk("s1_writes", 32'(n_writes - w0), 32'd8);
        chk("s1_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h01020304);
        chk("s1_word1", {mem[4], mem[5], mem[6], mem[7]}, 32'h05060708);

        // Scenario 2: one word with 3-cycle gaps between bytes.
        w0 = n_writes;
        start = 1'b1; len_words = 9'd1;
        tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 3; g++) begin
                byte_valid = 1'b0; byte_data = 8'h77;
                #1;
                chk("s2_gap_wr_en", 32'(wr_en), 32'd0);
                chk("s2_gap_hold", 32'(cpu_hold), 32'd1);
                chk("s2_gap_addr", wr_addr, 32'(i));
                tick();
            end
            byte_valid = 1'b1; byte_data = 8'(8'h10 + i);
            #1;
            chk("s2_hold", 32'(cpu_hold), 32'd1);
            chk("s2_wr_addr", wr_addr, 32'(i));
            tick();
        end
        byte_valid = 1'b0;
        #1 chk("s2_done", 32'(done), 32'd1);
        chk("s2_checksum", 32'(checksum), 32'h46);
        tick();
        chk("s2_writes", 32'(n_writes - w0), 32'd4);
        chk("s2_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h10111213);

        // Scenario 3: bad lengths raise err with no writes; a good start clears it.
        w0 = n_writes;
        start = 1'b1; len_words = 9'd0; byte_valid = 1'b1; byte_data = 8'h55;
        tick(); start = 1'b0;
        chk("s3_err_len0", 32'(err), 32'd1);
        chk("s3_err_wr_en", 32'(wr_en), 32'd0);
        chk("s3_err_hold", 32'(cpu_hold), 32'd0);
        chk("s3_err_ready", 32'(byte_ready), 32'd0);
        tick();
        chk("s3_err_sticky", 32'(err), 32'd1);
        chk("s3_idle_busy", 32'(busy), 32'd0);
        start = 1'b1; len_words = 9'd257;
        tick(); start = 1'b0;
        chk("s3_err_len257", 32'(err), 32'd1);
        chk("s3_err257_busy", 32'(busy), 32'd0);
        tick();
        chk("s3_no_writes", 32'(n_writes - w0), 32'd0);
        start = 1'b1; len_words = 9'd1; byte_valid = 1'b0;
        tick(); start = 1'b0;
        chk("s3_err_cleared", 32'(err), 32'd0);
        chk("s3_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1; byte_data = 8'h20; tick();
        end
        byte_valid = 1'b0;
        #1 chk("s3_done", 32'(done), 32'd1);
        tick();

        // Scenario 4: start re-pulsed during LOAD and DONE is ignored.
        w0 = n_writes;
        start = 1'b1; len_words = 9'd2;
        tick();
        len_words = 9'd5;
        for (int i = 0; i < 8; i++) begin
            start = (i == 2) || (i == 5);
            byte_valid = 1'b1; byte_data = 8'h30;
            tick();
        end
        byte_valid = 1'b0; start = 1'b1; len_words = 9'd1;
        #1 chk("s4_done", 32'(done), 32'd1);
        tick(); start = 1'b0;
        chk("s4_idle_after_done", 32'(busy), 32'd0);
        chk("s4_writes", 32'(n_writes - w0), 32'd8);
        chk("s4_checksum", 32'(checksum), 32'h80);

        // Scenario 5: reset after 5 of 8 bytes aborts the load.
        w0 = n_writes;
        start = 1'b1; len_words = 9'd2;
        tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            byte_valid = 1'b1; byte_data = 8'(8'hA0 + i); tick();
        end
        rst = 1'b1; byte_data = 8'hA5;
        #1;
        chk("s5_rst_wr_en", 32'(wr_en), 32'd0);
        chk("s5_rst_addr", wr_addr, 32'h0);
        chk("s5_rst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0; byte_valid = 1'b0;
        #1;
        chk("s5_idle", 32'(busy), 32'd0);
        chk("s5_checksum", 32'(checksum), 32'd0);
        chk("s5_no_done", 32'(done), 32'd0);
        chk("s5_writes", 32'(n_writes - w0), 32'd5);
        tick();
        start = 1'b1; len_words = 9'd1;
        tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1; byte_data = 8'(8'hB0 + i);
            #1 if (i == 0) chk("s5_restart_addr", wr_addr, 32'h0);
            tick();
        end
        byte_valid = 1'b0;
        tick();
        chk("s5_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'hB0B1B2B3);
        chk("s5_kept_byte", 32'(mem[4]), 32'hA4);

        // Scenario 6: full memory of 0xFF bytes.
        w0 = n_writes;
        start = 1'b1; len_words = 9'd256;
        tick(); start = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            byte_valid = 1'b1; byte_data = 8'hFF;
            #1 if (i == 1023) chk("s6_last_addr", wr_addr, 32'd1023);
            tick();
        end
        byte_valid = 1'b0;
        #1;
        chk("s6_done", 32'(done), 32'd1);
        chk("s6_checksum", 32'(checksum), 32'h00);
        chk("s6_writes", 32'(n_writes - w0), 32'd1024);
        chk("s6_last_write", last_addr, 32'd1023);
        tick();
        chk("s6_done_once", 32'(done), 32'd0);
        chk("s6_idle_addr", wr_addr, 32'h0);
        b = mem[1023];
        chk("s6_mem_top", 32'(b), 32'hFF);
        chk("addr_in_range", 32'(n_oob), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
